// File: rtl/rv32i_fetch.sv
`default_nettype none
// ==========================================================================
// Module  : rv32i_fetch
// Brief   : RV32I fetch unit - credit-limited imem requests, PC/instr FIFO to decode
// Revision: 1.0
// ==========================================================================
module rv32i_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h8000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        imem_rsp_err,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic        if_fault
);

  localparam int c_ptr_w = $clog2(FIFO_DEPTH);
  localparam int c_cnt_w = c_ptr_w + 1;
  localparam logic [c_cnt_w-1:0] c_cnt_one = c_cnt_w'(1);
  localparam logic [c_ptr_w-1:0] c_ptr_one = c_ptr_w'(1);
  localparam logic [c_cnt_w:0]   c_depth   = (c_cnt_w + 1)'(FIFO_DEPTH);

  logic [31:0]        r_pc;
  logic [31:0]        r_rsp_pc;
  logic               r_run;
  logic [c_cnt_w-1:0] r_outstanding;
  logic [c_cnt_w-1:0] r_drop_cnt;
  logic [c_cnt_w-1:0] r_count;
  logic [c_ptr_w-1:0] r_wr_ptr;
  logic [c_ptr_w-1:0] r_rd_ptr;
  logic [31:0]        r_fifo_instr [FIFO_DEPTH];
  logic [31:0]        r_fifo_pc    [FIFO_DEPTH];
  logic               r_fifo_err   [FIFO_DEPTH];

  logic               w_credit;
  logic               w_req_fire;
  logic               w_rsp_fire;
  logic               w_drop;
  logic               w_push;
  logic               w_pop;
  logic [c_cnt_w-1:0] w_out_next;
  logic [c_cnt_w-1:0] w_count_next;
  logic [31:0]        w_target;
  logic               w_unused;

  assign w_target = {redirect_pc[31:2], 2'b00};
  assign w_unused = ^redirect_pc[1:0];

  // Every buffer slot is reserved from request acceptance until decode pops it.
  assign w_credit       = ({1'b0, r_count} + {1'b0, r_outstanding}) < c_depth;
  assign imem_req_valid = r_run & w_credit & ~redirect_valid;
  assign imem_req_addr  = r_pc;

  assign w_req_fire = imem_req_valid & imem_req_ready;
  assign w_rsp_fire = imem_rsp_valid & (r_outstanding != '0);
  assign w_drop     = (r_drop_cnt != '0) | redirect_valid;
  assign w_push     = w_rsp_fire & ~w_drop;
  assign w_pop      = if_valid & if_ready & ~redirect_valid;

  assign if_valid = (r_count != '0);
  assign if_instr = if_valid ? r_fifo_instr[r_rd_ptr] : 32'd0;
  assign if_pc    = if_valid ? r_fifo_pc[r_rd_ptr]    : 32'd0;
  assign if_fault = if_valid & r_fifo_err[r_rd_ptr];

  always_comb begin
    w_out_next = r_outstanding;
    if (w_req_fire && !w_rsp_fire) begin
      w_out_next = r_outstanding + c_cnt_one;
    end else if (!w_req_fire && w_rsp_fire) begin
      w_out_next = r_outstanding - c_cnt_one;
    end
  end

  always_comb begin
    w_count_next = r_count;
    if (w_push && !w_pop) begin
      w_count_next = r_count + c_cnt_one;
    end else if (!w_push && w_pop) begin
      w_count_next = r_count - c_cnt_one;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pc          <= RESET_PC;
      r_rsp_pc      <= RESET_PC;
      r_run         <= 1'b0;
      r_outstanding <= '0;
      r_drop_cnt    <= '0;
      r_count       <= '0;
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
    end else begin
      r_run         <= 1'b1;
      r_outstanding <= w_out_next;
      if (redirect_valid) begin
        // Everything still in flight after this cycle belongs to the old stream.
        r_pc       <= w_target;
        r_rsp_pc   <= w_target;
        r_drop_cnt <= w_out_next;
        r_count    <= '0;
        r_wr_ptr   <= '0;
        r_rd_ptr   <= '0;
      end else begin
        if (w_req_fire) begin
          r_pc <= r_pc + 32'd4;
        end
        if (w_rsp_fire && (r_drop_cnt != '0)) begin
          r_drop_cnt <= r_drop_cnt - c_cnt_one;
        end
        if (w_push) begin
          r_wr_ptr <= r_wr_ptr + c_ptr_one;
          r_rsp_pc <= r_rsp_pc + 32'd4;
        end
        if (w_pop) begin
          r_rd_ptr <= r_rd_ptr + c_ptr_one;
        end
        r_count <= w_count_next;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_instr[r_wr_ptr] <= imem_rsp_data;
      r_fifo_pc[r_wr_ptr]    <= r_rsp_pc;
      r_fifo_err[r_wr_ptr]   <= imem_rsp_err;
    end
  end

  a_rsp_has_credit: assert property (@(posedge clk) disable iff (!rst_n)
    imem_rsp_valid |-> (r_outstanding != '0));

endmodule
`default_nettype wire

// File: tb/tb_rv32i_fetch.sv
`default_nettype none
// ==========================================================================
// Module  : tb_rv32i_fetch
// Brief   : Scoreboard bench for rv32i_fetch with a latency-configurable imem model
// Revision: 1.0
// ==========================================================================
module tb_rv32i_fetch;

  localparam logic [31:0] c_reset_pc = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        imem_rsp_err;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        if_fault;

  always #5 clk = ~clk;

  rv32i_fetch #(
    .RESET_PC   (c_reset_pc),
    .FIFO_DEPTH (2)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .imem_rsp_err   (imem_rsp_err),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
    .if_fault       (if_fault)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        fault;
  } exp_t;

  typedef struct packed {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  exp_t        sb_q[$];
  mreq_t       mem_q[$];
  logic [31:0] redir_addrs[$];
  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  int          lat = 1;
  int          pops = 0;
  int          faults_seen = 0;
  int          first_req_cyc = -1;
  int          first_valid_cyc = -1;
  int          pops_mark;
  bit          mem_rand_ready = 1'b0;
  bit          redir_pop_pending = 1'b0;
  bit          found;
  logic [31:0] model_pc = c_reset_pc;
  logic [31:0] first_pc_after_redir = 32'd0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  function automatic logic mem_fault(input logic [31:0] a);
    return a == 32'h8000_0008;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Runs at the falling edge: decides what the coming rising edge will transfer.
  task automatic monitor();
    exp_t e;
    if (!rst_n) begin
      sb_q.delete();
      mem_q.delete();
      model_pc        = c_reset_pc;
      first_req_cyc   = -1;
      first_valid_cyc = -1;
      faults_seen     = 0;
    end else begin
      if (if_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (redirect_valid) begin
        check_eq("req_blocked_on_redirect", {31'b0, imem_req_valid}, 32'd0);
        sb_q.delete();
        redir_addrs.delete();
        model_pc          = {redirect_pc[31:2], 2'b00};
        redir_pop_pending = 1'b1;
      end else if (if_valid && if_ready) begin
        if (sb_q.size() == 0) begin
          check_eq("sb_extra_output", {31'b0, if_valid}, 32'd0);
        end else begin
          e = sb_q.pop_front();
          check_eq("if_pc", if_pc, e.pc);
          check_eq("if_instr", if_instr, e.instr);
          check_eq("if_fault", {31'b0, if_fault}, {31'b0, e.fault});
          pops++;
          if (if_fault) faults_seen++;
          if (redir_pop_pending) begin
            first_pc_after_redir = if_pc;
            redir_pop_pending    = 1'b0;
          end
        end
      end
      if (imem_req_valid && imem_req_ready) begin
        check_eq("req_addr", imem_req_addr, model_pc);
        if (first_req_cyc < 0) first_req_cyc = cyc;
        sb_q.push_back('{pc: model_pc, instr: mem_word(model_pc), fault: mem_fault(model_pc)});
        mem_q.push_back('{addr: imem_req_addr, due: cyc + lat});
        redir_addrs.push_back(imem_req_addr);
        model_pc = model_pc + 32'd4;
      end
    end
  endtask

  task automatic mem_drive();
    mreq_t m;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'd0;
    imem_rsp_err   = 1'b0;
    if (!rst_n) begin
      mem_q.delete();
    end else if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
      m = mem_q.pop_front();
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_word(m.addr);
      imem_rsp_err   = mem_fault(m.addr);
    end
    imem_req_ready = mem_rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
  endtask

  // Returns 2 time units after the rising edge; callers check and drive there.
  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      monitor();
      @(posedge clk);
      cyc++;
      #1;
      mem_drive();
      #1;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'd0;
    if_ready       = 1'b0;
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'd0;
    imem_rsp_err   = 1'b0;

    step(3);
    check_eq("rst_if_valid", {31'b0, if_valid}, 32'd0);
    check_eq("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
    check_eq("rst_if_instr", if_instr, 32'd0);
    check_eq("rst_if_pc", if_pc, 32'd0);
    check_eq("rst_if_fault", {31'b0, if_fault}, 32'd0);

    // Decode stalled from the start: the buffer fills and requests stop.
    rst_n = 1'b1;
    step(12);
    check_eq("stall_if_valid", {31'b0, if_valid}, 32'd1);
    check_eq("stall_req_valid", {31'b0, imem_req_valid}, 32'd0);
    check_eq("stall_head_pc", if_pc, 32'h8000_0000);
    if_ready = 1'b1;
    step(3);
    if_ready = 1'b0;
    step(8);
    check_eq("refill_if_valid", {31'b0, if_valid}, 32'd1);
    check_eq("refill_req_valid", {31'b0, imem_req_valid}, 32'd0);

    // One-cycle reset while full.
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
    check_eq("midrst_if_valid", {31'b0, if_valid}, 32'd0);
    check_eq("midrst_req_valid", {31'b0, imem_req_valid}, 32'd0);
    if_ready = 1'b1;
    step(7);
    check_eq("first_valid_latency", first_valid_cyc - first_req_cyc, 32'd2);
    pops_mark = pops;
    step(12);
    check_eq("steady_rate_ok", {31'b0, (pops - pops_mark) >= 8}, 32'd1);
    check_eq("single_fault_seen", faults_seen, 32'd1);

    // Redirect with two requests in flight.
    lat   = 2;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      step(1);
      if (!imem_req_valid && !if_valid) found = 1'b1;
    end
    check_eq("two_outstanding_found", {30'b0, imem_req_valid, if_valid}, 32'd0);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_1002;
    step(1);
    redirect_valid = 1'b0;
    check_eq("redir_if_valid_n1", {31'b0, if_valid}, 32'd0);
    check_eq("redir_addr_n1", imem_req_addr, 32'h0000_1000);
    step(10);
    check_eq("redir_first_pc", first_pc_after_redir, 32'h0000_1000);

    // Back-to-back redirects: the second one wins.
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_2000;
    step(1);
    redirect_pc    = 32'h0000_3006;
    step(1);
    redirect_valid = 1'b0;
    step(10);
    check_eq("b2b_redir_first_pc", first_pc_after_redir, 32'h0000_3004);

    // Address wrap at the top of the address space.
    lat            = 1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    step(1);
    redirect_valid = 1'b0;
    step(10);
    check_eq("wrap_count_ok", {31'b0, redir_addrs.size() >= 3}, 32'd1);
    check_eq("wrap_addr0", redir_addrs[0], 32'hFFFF_FFFC);
    check_eq("wrap_addr1", redir_addrs[1], 32'h0000_0000);
    check_eq("wrap_addr2", redir_addrs[2], 32'h0000_0004);
    check_eq("wrap_first_pc", first_pc_after_redir, 32'hFFFF_FFFC);

    // Random backpressure, latency and redirects; the scoreboard checks every pop.
    mem_rand_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      step(1);
      redirect_valid = ($urandom_range(0, 19) == 0);
      redirect_pc    = $urandom;
      if_ready       = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 15) == 0) lat = $urandom_range(1, 3);
    end
    redirect_valid = 1'b0;
    mem_rand_ready = 1'b0;
    if_ready       = 1'b1;
    step(10);
    check_eq("progress_ok", {31'b0, pops > 100}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
